// File: rtl/axis_rx_pkg.sv
// Shared constants and helpers for the AXI-Stream receive buffer.
// The stored beat word is packed MSB to LSB as {user, dest, id, last, strb, keep, data}.
package axis_rx_pkg;

    localparam int DROP_W = 8;

    function automatic int fifo_addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int beat_w(input int dw, input int iw, input int dsw, input int uw);
        return uw + dsw + iw + 1 + 2 * (dw / 8) + dw;
    endfunction

endpackage

// File: rtl/axis_rx_fifo_mem.sv
// DEPTH x W register array: synchronous write, combinational read at the read pointer.
module axis_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_rx_buffer.sv
// AXI-Stream sink: FWFT beat buffer with null-beat filter, packet counter
// and a sticky flag for transmitter handshake-stability violations.
module axis_rx_buffer
    import axis_rx_pkg::*;
#(
    parameter int TDATA_WIDTH = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 8,
    parameter int DEPTH       = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           TVALID,
    output logic                           TREADY,
    input  logic [TDATA_WIDTH-1:0]         TDATA,
    input  logic [TDATA_WIDTH/8-1:0]       TKEEP,
    input  logic [TDATA_WIDTH/8-1:0]       TSTRB,
    input  logic                           TLAST,
    input  logic [TID_WIDTH-1:0]           TID,
    input  logic [TDEST_WIDTH-1:0]         TDEST,
    input  logic [TUSER_WIDTH-1:0]         TUSER,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [TDATA_WIDTH-1:0]         m_data,
    output logic [TDATA_WIDTH/8-1:0]       m_keep,
    output logic [TDATA_WIDTH/8-1:0]       m_strb,
    output logic                           m_last,
    output logic [TID_WIDTH-1:0]           m_id,
    output logic [TDEST_WIDTH-1:0]         m_dest,
    output logic [TUSER_WIDTH-1:0]         m_user,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic [$clog2(DEPTH+1)-1:0]     pkt_count,
    output logic [DROP_W-1:0]              drop_count,
    output logic                           err_stable
);

    localparam int AW = fifo_addr_w(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = beat_w(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          tready_q;
    logic          accept, is_null, push, pop;
    logic          pend;
    logic [BW-1:0] wr_word, rd_word, head_word, held_word;

    assign TREADY  = tready_q;
    assign accept  = TVALID & tready_q;
    assign is_null = (TKEEP == '0) & ~TLAST;
    assign push    = accept & ~is_null;
    assign m_valid = (level != '0);
    assign pop     = m_valid & m_ready;
    assign wr_word = {TUSER, TDEST, TID, TLAST, TSTRB, TKEEP, TDATA};

    // Head fields read as zero whenever the buffer is empty, including in reset.
    assign head_word = m_valid ? rd_word : '0;
    assign {m_user, m_dest, m_id, m_last, m_strb, m_keep, m_data} = head_word;

    axis_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (BW),
        .AW    (AW)
    ) u_mem (
        .clk   (ACLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_comb begin
        level_nxt = level;
        if (push & ~pop)      level_nxt = level + LW'(1);
        else if (pop & ~push) level_nxt = level - LW'(1);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            tready_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level    <= level_nxt;
            // Registered full: TREADY never follows TVALID combinationally.
            tready_q <= (level_nxt != FULL_LVL);
            if ((push & TLAST) & ~(pop & m_last))
                pkt_count <= pkt_count + LW'(1);
            else if ((pop & m_last) & ~(push & TLAST))
                pkt_count <= pkt_count - LW'(1);
            if (accept & is_null & ~&drop_count)
                drop_count <= drop_count + DROP_W'(1);
        end
    end

    // A beat offered without TREADY must reappear unchanged on the next edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pend       <= 1'b0;
            err_stable <= 1'b0;
        end else begin
            pend <= TVALID & ~tready_q;
            if (pend && (!TVALID || (wr_word != held_word)))
                err_stable <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        held_word <= wr_word;
    end

endmodule

// File: tb/tb_axis_rx_buffer.sv
// Directed bench for axis_rx_buffer: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_axis_rx_buffer;

    logic       ACLK;
    logic       ARESET;
    logic       TVALID;
    logic       TREADY;
    logic [7:0] TDATA;
    logic [0:0] TKEEP;
    logic [0:0] TSTRB;
    logic       TLAST;
    logic [7:0] TID;
    logic [7:0] TDEST;
    logic [0:0] TUSER;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [0:0] m_keep;
    logic [0:0] m_strb;
    logic       m_last;
    logic [7:0] m_id;
    logic [7:0] m_dest;
    logic [0:0] m_user;
    logic [4:0] level;
    logic [4:0] pkt_count;
    logic [7:0] drop_count;
    logic       err_stable;

    axis_rx_buffer dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .TVALID     (TVALID),
        .TREADY     (TREADY),
        .TDATA      (TDATA),
        .TKEEP      (TKEEP),
        .TSTRB      (TSTRB),
        .TLAST      (TLAST),
        .TID        (TID),
        .TDEST      (TDEST),
        .TUSER      (TUSER),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_strb     (m_strb),
        .m_last     (m_last),
        .m_id       (m_id),
        .m_dest     (m_dest),
        .m_user     (m_user),
        .level      (level),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .err_stable (err_stable)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored beats, ordered {data,keep,strb,last,id,dest,user}.
    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       strb;
        logic       last;
        logic [7:0] id;
        logic [7:0] dest;
        logic       user;
    } beat_t;

    beat_t q[$];
    bit    mrdy;
    int    mdrop;
    bit    merr, mpend;
    beat_t mprev, cur;
    bit    popn;

    function automatic int mdl_pkts();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            q.delete();
            mrdy  = 1'b0;
            mdrop = 0;
            merr  = 1'b0;
            mpend = 1'b0;
        end else begin
            cur = {TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER};
            if (mpend && (!TVALID || cur != mprev)) merr = 1'b1;
            mpend = TVALID && !mrdy;
            mprev = cur;
            popn  = m_ready && (q.size() > 0);
            if (popn) void'(q.pop_front());
            if (TVALID && mrdy) begin
                if (cur.keep == 1'b0 && !cur.last) begin
                    if (mdrop < 255) mdrop++;
                end else begin
                    q.push_back(cur);
                end
            end
            mrdy = (q.size() != 16);
        end
    end

    logic [8:0] dut_log[$];

    always @(negedge ACLK) begin
        chk("tready", 64'(TREADY), 64'(mrdy));
        chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
        chk("level", 64'(level), 64'(q.size()));
        chk("pkt_count", 64'(pkt_count), 64'(mdl_pkts()));
        chk("drop_count", 64'(drop_count), 64'(mdrop));
        chk("err_stable", 64'(err_stable), 64'(merr));
        if (q.size() > 0)
            chk("head", 64'({m_data, m_keep, m_strb, m_last, m_id, m_dest, m_user}), 64'(q[0]));
        if (m_valid && m_ready) dut_log.push_back({m_last, m_data});
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic l);
        TVALID = v;
        TDATA  = d;
        TKEEP  = k;
        TSTRB  = k;
        TLAST  = l;
        TID    = d ^ 8'h3C;
        TDEST  = ~d;
        TUSER  = d[0];
    endtask

    task automatic push_beat(input logic [7:0] d, input logic k, input logic l);
        bit acc;
        drive(1'b1, d, k, l);
        for (int n = 0; n < 64; n++) begin
            acc = TREADY;
            step();
            if (acc) return;
        end
        total++;
        bad++;
        $display("FAIL push_timeout: beat %0h not accepted within 64 cycles", d);
    endtask

    task automatic drain();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        m_ready = 1'b1;
        for (int n = 0; n < 40 && m_valid; n++) step();
        chk("drain_empty", 64'(m_valid), 64'(0));
        m_ready = 1'b0;
        step();
    endtask

    task automatic chk_log(input string nm, input logic [8:0] exp[$]);
        chk({nm, "_len"}, 64'(dut_log.size()), 64'(exp.size()));
        foreach (exp[i])
            if (i < dut_log.size()) chk(nm, 64'(dut_log[i]), 64'(exp[i]));
    endtask

    initial begin
        ARESET  = 1'b1;
        m_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst_tready", 64'(TREADY), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        ARESET = 1'b0;
        step();
        chk("tready_after_rst", 64'(TREADY), 64'(1));

        // Four-beat packet streamed straight through.
        dut_log.delete();
        m_ready = 1'b1;
        push_beat(8'h11, 1'b1, 1'b0);
        push_beat(8'h22, 1'b1, 1'b0);
        push_beat(8'h33, 1'b1, 1'b0);
        push_beat(8'h44, 1'b1, 1'b1);
        drain();
        chk_log("pkt4", '{9'h011, 9'h022, 9'h033, 9'h144});
        chk("pkt4_count", 64'(pkt_count), 64'(0));

        // Null beat is dropped; keep=0 with last=1 is stored.
        dut_log.delete();
        m_ready = 1'b1;
        push_beat(8'hAA, 1'b1, 1'b0);
        push_beat(8'h99, 1'b0, 1'b0);
        push_beat(8'hBB, 1'b1, 1'b0);
        push_beat(8'hCC, 1'b0, 1'b1);
        drain();
        chk_log("null", '{9'h0AA, 9'h0BB, 9'h1CC});
        chk("drop_count1", 64'(drop_count), 64'(1));

        // Fill to DEPTH, then one pop admits exactly one more beat.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(8'(i), 1'b1, 1'b0);
        chk("full_tready", 64'(TREADY), 64'(0));
        drive(1'b1, 8'h10, 1'b1, 1'b0);
        step();
        step();
        chk("full_level", 64'(level), 64'(16));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("pop1_tready", 64'(TREADY), 64'(1));
        chk("pop1_level", 64'(level), 64'(15));
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("refill_tready", 64'(TREADY), 64'(0));
        chk("refill_level", 64'(level), 64'(16));
        step();
        chk("refill_hold", 64'(level), 64'(16));
        drain();

        // Sustained push+pop at level 8.
        dut_log.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_beat(8'h40 + 8'(i), 1'b1, 1'b0);
        m_ready = 1'b1;
        for (int i = 8; i < 28; i++) begin
            drive(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
            step();
        end
        m_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("steady_level", 64'(level), 64'(8));
        chk("steady_len", 64'(dut_log.size()), 64'(20));
        for (int i = 0; i < 20 && i < dut_log.size(); i++)
            chk("steady_seq", 64'(dut_log[i]), 64'(9'h040 + 9'(i)));
        drain();

        // Data change while stalled sets the sticky error.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(8'h60 + 8'(i), 1'b1, 1'b0);
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        step();
        step();
        chk("stable_ok", 64'(err_stable), 64'(0));
        drive(1'b1, 8'h5B, 1'b1, 1'b0);
        step();
        chk("stable_err", 64'(err_stable), 64'(1));
        m_ready = 1'b1;
        step();
        step();
        step();
        drain();
        chk("stable_sticky", 64'(err_stable), 64'(1));

        // Reset mid-packet at level 5 clears everything immediately.
        m_ready = 1'b0;
        push_beat(8'h71, 1'b1, 1'b1);
        for (int i = 2; i < 6; i++) push_beat(8'h70 + 8'(i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'(5));
        chk("pre_rst_pkts", 64'(pkt_count), 64'(1));
        ARESET = 1'b1;
        #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_pkts", 64'(pkt_count), 64'(0));
        chk("mid_rst_tready", 64'(TREADY), 64'(0));
        chk("mid_rst_err", 64'(err_stable), 64'(0));
        step();
        step();
        ARESET = 1'b0;
        step();
        dut_log.delete();
        m_ready = 1'b1;
        push_beat(8'h81, 1'b1, 1'b0);
        push_beat(8'h82, 1'b1, 1'b0);
        push_beat(8'h83, 1'b1, 1'b1);
        drain();
        chk_log("post_rst", '{9'h081, 9'h082, 9'h183});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_rx_buffer.md
# axis_rx_buffer

AXI-Stream receiver endpoint: drives TREADY, accepts beats from an upstream transmitter, and buffers them in a DEPTH-entry first-word-fall-through FIFO. Buffered beats are presented on a local valid/ready pop port. The block also:
- drops null beats;
- counts complete packets held in the buffer;
- flags transmitter-side handshake-stability violations.

It sits at the sink end of any AXI-Stream link in the design, in front of packet-consuming logic.

## Interface
Parameters:
- TDATA_WIDTH, 8, data width in bits; multiple of 8.
- TDEST_WIDTH, 8, TDEST width.
- TUSER_WIDTH, 1, TUSER width.
- TID_WIDTH, 8, TID width.
- DEPTH, 16, FIFO entries; power of 2, ≥ 2.

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- TVALID  in  1  upstream beat valid.
- TREADY  out  1  buffer can accept a beat.
- TDATA  in  TDATA_WIDTH  beat data.
- TKEEP  in  TDATA_WIDTH/8  non-null byte mask.
- TSTRB  in  TDATA_WIDTH/8  data/position byte mask.
- TLAST  in  1  packet boundary.
- TID / TDEST / TUSER  in  TID_WIDTH / TDEST_WIDTH / TUSER_WIDTH  sideband.
- m_valid  out  1  head beat valid.
- m_ready  in  1  consumer pops the head beat.
- m_data, m_keep, m_strb, m_last, m_id, m_dest, m_user  out  same widths as inputs  head-beat fields.
- level  out  $clog2(DEPTH+1)  entries occupied.
- pkt_count  out  $clog2(DEPTH+1)  stored beats with last=1.
- drop_count  out  8  null beats discarded; saturates at 255.
- err_stable  out  1  sticky stability-violation flag.

## Operation
- Reset values: TREADY=0 during reset; TREADY=1 from the first edge after ARESET deasserts. All other outputs reset to 0, including m_valid and all m_* fields.
- Accept: a beat is accepted on an edge where TVALID & TREADY.
- TREADY = ~full, where full is registered (level==DEPTH). TREADY never depends combinationally on TVALID.
- Null beat: TKEEP==0 and TLAST==0. It is accepted (handshake completes) but not stored, and drop_count increments.
- Beats with TKEEP==0 and TLAST==1 are stored; they carry the packet boundary.
- Pop: an edge with m_valid & m_ready removes the head beat. m_* fields hold while m_valid & ~m_ready.
- level tracks stored beats: push only → +1; pop only → −1; push and pop on the same edge → unchanged.
- pkt_count: +1 when a stored beat has TLAST=1; −1 when a popped beat has m_last=1; a same-edge pair cancels.
- Stability check, with an internal register pend set when TVALID & ~TREADY:
  - On the next edge, TVALID must still be 1, and TDATA, TKEEP, TSTRB, TLAST, TID, TDEST and TUSER must all be unchanged.
  - Otherwise err_stable is set; it stays set until reset.
  - The check only flags; beats are still accepted.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by level.

## Timing
- Write-to-read latency: a beat accepted at edge N gives m_valid=1 in the cycle after edge N, when the FIFO was empty.
- Full: no push is possible. A pop at edge N raises TREADY after edge N, so the next push is at edge N+1.
- Empty: m_valid=0. A pop request is ignored and the m_* fields are don't-care.
- Reset mid-packet:
  - Buffer contents, pointers and counters clear immediately (asynchronously).
  - The partial packet is lost; there is no flush handshake.
- Throughput: one beat in and one beat out per cycle sustained when 0 < level < DEPTH.

## Structure
- Package axis_rx_pkg:
  - FIFO address-width function.
  - drop_count width constant (8).
  - Packing order of the stored-beat word {user, dest, id, last, strb, keep, data}.
- Sub-module axis_rx_fifo_mem: a DEPTH×W dual-port register array, with synchronous write and combinational read at the read pointer.
- The top level holds pointers, counters, the null-beat filter and the stability checker.

## Test plan
- Reset, then 4-beat packet 0x11,0x22,0x33,0x44 (TKEEP=1, last on beat 4) with m_ready=1 → m_data appears in order one cycle after each accept; m_last on the 4th beat; pkt_count 0→1→0.
- m_ready=0 with continuous TVALID, DEPTH=16 → TREADY falls after the 16th accept; level=16. Raise m_ready for one cycle → TREADY=1 in the next cycle, and exactly one more beat is accepted.
- Beat with TKEEP=0, TLAST=0 between 0xAA and 0xBB → only 0xAA, 0xBB popped; drop_count=1. A beat with TKEEP=0, TLAST=1 → stored, m_last=1.
- While full, change TDATA from 0x5A to 0x5B with TVALID held → err_stable=1 next cycle, stays 1 after further traffic, and clears only on ARESET.
- Simultaneous push and pop at level=8 for 20 cycles → level stays 8; the output sequence equals the input sequence.
- ARESET pulse mid-packet at level=5 → same cycle: m_valid=0, level=0, pkt_count=0, TREADY=0; after release, a new packet passes cleanly.
